prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Program-flow sequencer for the 9-bit-instruction core. It owns the program counter, the 16-entry jump-target LUT addressed by the decoder's `LutPointer`, and the run/stall/halt state machine. It sits between instruction memory (fed by `pc`) and the combinational decoder, whose `pc_jmp_en`, memory-access and halt indications it consumes. It also produces the per-instruction `retire` strobe that gates register-file and data-memory writes, and the `start`/`done` handshake seen by the testbench and top level.

## Interface
- `PC_W`, 10, program counter width; instruction memory depth is 2^PC_W.
- `START_PC`, 0, PC value loaded when a run is accepted.
- `MEM_LAT`, 1, extra cycles a `ldr`/`str`/`ldi`/`sti` instruction occupies; 0 means no stall.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; forces all state to reset values.
- `start`  in  1  run request from top level; level-sensitive.
- `pc_jmp_en`  in  1  decoder jump-taken indication for the current instruction.
- `lut_ptr`  in  4  decoder `LutPointer`; selects the jump target.
- `mem_access`  in  1  current instruction is a data-memory load or store.
- `halt_instr`  in  1  current instruction is the halt encoding.
- `lut_wr_en`  in  1  jump-LUT write strobe; honoured only in IDLE.
- `lut_wr_addr`  in  4  jump-LUT write index.
- `lut_wr_data`  in  PC_W  jump-LUT write value.
- `pc`  out  PC_W  registered program counter; addresses instruction memory.
- `retire`  out  1  current instruction commits this cycle; combinational from state and inputs.
- `stall`  out  1  high in STALL state.
- `busy`  out  1  high in RUN or STALL.
- `done`  out  1  high in DONE state.
- `cycle_count`  out  16  cycles spent in RUN+STALL for the current or last run.

## Operation
- States: IDLE, RUN, STALL, DONE. The state is registered. A stall counter of width clog2(MEM_LAT+1) is registered. The LUT is 16 x PC_W registers.
- Reset: state=IDLE, `pc`=0, stall counter=0, `cycle_count`=0, all LUT entries=0. Every output is 0 at reset.
- IDLE:
  - A `lut_wr_en` writes `lut[lut_wr_addr]` on the edge.
  - `start`=1 moves to RUN, loads `pc`=START_PC and clears `cycle_count`.
  - `retire`=0.
- RUN: the decoder inputs describe the instruction at `pc`. Priority is highest first:
  - `halt_instr`: `retire`=1, `pc` holds, go to DONE.
  - `mem_access` with MEM_LAT>0: `retire`=0, `pc` holds, load stall counter=MEM_LAT, go to STALL.
  - `pc_jmp_en`: `retire`=1, `pc` <= `lut[lut_ptr]`.
  - Otherwise: `retire`=1, `pc` <= `pc`+1, modulo 2^PC_W (all-ones wraps to 0).
- STALL:
  - The counter decrements each cycle and `pc` holds.
  - When the counter==1: `retire`=1, `pc` <= `pc`+1, go to RUN.
  - A mem instruction therefore occupies 1+MEM_LAT cycles. Jump and halt inputs are ignored in STALL.
- DONE:
  - `done`=1; `pc` and `cycle_count` hold.
  - `start`=0 returns to IDLE, and `done` falls on the next cycle.
  - `start` held high keeps DONE, so a new run requires `start` to go low and then high again.
- `cycle_count` increments on every RUN or STALL cycle, including the halting cycle, and saturates at 0xFFFF.
- LUT writes outside IDLE are ignored. A LUT read uses the current register contents, with no bypass.
- Reset asserted in any state, mid-stall included, overrides everything and gives the reset values on the next edge.

## Timing
- `start` is sampled at an edge in IDLE. The first RUN cycle follows that edge with `pc`=START_PC.
- PC update latency is 1 cycle: the next-PC decision made in cycle N is visible on `pc` in cycle N+1.
- A taken jump costs 1 cycle, with no bubble.
- `retire`, `stall`, `busy` and `done` are valid in the same cycle as the state. `retire` is combinational and must be sampled before the edge.
- Halt at cycle N gives `done`=1 from cycle N+1.
- A LUT write at edge E is readable from cycle E+1.

## Test plan
- Reset, then check outputs: `pc`=0, `done`=0, `busy`=0, `cycle_count`=0. Then `start`=1 with no special inputs for 5 cycles: `pc` steps 0,1,2,3,4, `retire`=1 every cycle, `cycle_count`=5.
- In IDLE write `lut[3]`=0x120. Run, then assert `pc_jmp_en`=1 with `lut_ptr`=3 at `pc`=2: next cycle `pc`=0x120. Repeat with a LUT write attempted during RUN: the entry is unchanged.
- MEM_LAT=1, `mem_access`=1 at `pc`=5: one cycle with `retire`=0 then one STALL cycle with `retire`=1, `stall`=1, then `pc`=6. Total 2 cycles; `cycle_count` advances by 2. MEM_LAT=3 gives 4 cycles.
- `halt_instr`=1 together with `pc_jmp_en`=1 and `mem_access`=1 at `pc`=7: `retire`=1, `pc` stays 7, `done`=1 next cycle. `done` holds while `start`=1; drop `start`, and one cycle later state is IDLE with `done`=0.
- PC_W=4 with `pc`=15 and no jump: `pc` wraps to 0. Run for more than 65535 cycles: `cycle_count` saturates at 0xFFFF.
- Assert `reset` during STALL with `pc`=0x33: the next cycle shows IDLE, `pc`=0, `stall`=0, and `lut[3]` reads 0.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program-flow sequencer: owns the PC, the 16-entry jump-target LUT and the run/stall/halt FSM.
// PC updates with 1-cycle latency; memory ops hold the PC for MEM_LAT extra cycles and retire on the last one.
module prog_sequencer #(
  parameter int PC_W     = 10,
  parameter int START_PC = 0,
  parameter int MEM_LAT  = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            pc_jmp_en_i,
  input  logic [3:0]      lut_ptr_i,
  input  logic            mem_access_i,
  input  logic            halt_instr_i,
  input  logic            lut_wr_en_i,
  input  logic [3:0]      lut_wr_addr_i,
  input  logic [PC_W-1:0] lut_wr_data_i,
  output logic [PC_W-1:0] pc_o,
  output logic            retire_o,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [15:0]     cycle_count_o
);

  localparam int               CNT_W     = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
  localparam logic [PC_W-1:0]  PC_START  = PC_W'(START_PC);
  localparam logic [PC_W-1:0]  PC_ONE    = PC_W'(1);
  localparam bit               HAS_STALL = (MEM_LAT > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STALL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      cyc_q, cyc_d;
  logic [PC_W-1:0]  lut_q [16];
  logic             lut_we;
  logic             retire;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
    end
  end

  // The LUT is only written from IDLE; reads see the registered contents only.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < 16; k++) begin
        lut_q[k] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_wr_addr_i] <= lut_wr_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    lut_we  = 1'b0;
    retire  = 1'b0;

    // Every RUN/STALL cycle is counted, saturating at all-ones.
    if ((state_q == S_RUN || state_q == S_STALL) && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        lut_we = lut_wr_en_i;
        if (start_i) begin
          state_d = S_RUN;
          pc_d    = PC_START;
          cyc_d   = '0;
        end
      end
      S_RUN: begin
        if (halt_instr_i) begin
          retire  = 1'b1;
          state_d = S_DONE;
        end else if (HAS_STALL && mem_access_i) begin
          cnt_d   = CNT_LOAD;
          state_d = S_STALL;
        end else if (pc_jmp_en_i) begin
          retire = 1'b1;
          pc_d   = lut_q[lut_ptr_i];
        end else begin
          retire = 1'b1;
          pc_d   = pc_q + PC_ONE;
        end
      end
      S_STALL: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          retire  = 1'b1;
          pc_d    = pc_q + PC_ONE;
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        // A new run needs start to drop first, so a held start parks here.
        if (!start_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc_o          = pc_q;
  assign retire_o      = retire;
  assign stall_o       = (state_q == S_STALL);
  assign busy_o        = (state_q == S_RUN) || (state_q == S_STALL);
  assign done_o        = (state_q == S_DONE);
  assign cycle_count_o = cyc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: two instances (PC_W=10/MEM_LAT=1 and PC_W=4/MEM_LAT=3) against a behavioural model.
module tb_prog_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_start, a_jmp, a_mem, a_halt, a_we;
  logic [3:0] a_ptr, a_waddr;
  logic [9:0] a_wdata, a_pc;
  logic       a_retire, a_stall, a_busy, a_done;
  logic [15:0] a_cyc;

  logic       b_rst, b_start, b_jmp, b_mem, b_halt, b_we;
  logic [3:0] b_ptr, b_waddr;
  logic [3:0] b_wdata, b_pc;
  logic       b_retire, b_stall, b_busy, b_done;
  logic [15:0] b_cyc;

  prog_sequencer #(.PC_W(10), .START_PC(0), .MEM_LAT(1)) u_a (
    .clk_i(clk), .reset_i(a_rst), .start_i(a_start), .pc_jmp_en_i(a_jmp),
    .lut_ptr_i(a_ptr), .mem_access_i(a_mem), .halt_instr_i(a_halt),
    .lut_wr_en_i(a_we), .lut_wr_addr_i(a_waddr), .lut_wr_data_i(a_wdata),
    .pc_o(a_pc), .retire_o(a_retire), .stall_o(a_stall), .busy_o(a_busy),
    .done_o(a_done), .cycle_count_o(a_cyc)
  );

  prog_sequencer #(.PC_W(4), .START_PC(0), .MEM_LAT(3)) u_b (
    .clk_i(clk), .reset_i(b_rst), .start_i(b_start), .pc_jmp_en_i(b_jmp),
    .lut_ptr_i(b_ptr), .mem_access_i(b_mem), .halt_instr_i(b_halt),
    .lut_wr_en_i(b_we), .lut_wr_addr_i(b_waddr), .lut_wr_data_i(b_wdata),
    .pc_o(b_pc), .retire_o(b_retire), .stall_o(b_stall), .busy_o(b_busy),
    .done_o(b_done), .cycle_count_o(b_cyc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: run flag, remaining wait cycles, finished flag, pc, counter, LUT.
  int m_run  [2];
  int m_wait [2];
  int m_fin  [2];
  int m_pc   [2];
  int m_cyc  [2];
  int m_lut  [2][16];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int pcmod_of(input int i);
    return (i == 0) ? 1024 : 16;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    if (obs !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_retire(input int i, input logic mem, input logic halt);
    if (m_run[i] == 0) return 0;
    if (m_wait[i] > 0) return (m_wait[i] == 1) ? 1 : 0;
    if (halt) return 1;
    if (mem && lat_of(i) > 0) return 0;
    return 1;
  endfunction

  task automatic model_step(input int i, input logic rst, input logic st, input logic jmp,
                            input logic [3:0] ptr, input logic mem, input logic halt,
                            input logic we, input logic [3:0] waddr, input int wdata);
    if (rst) begin
      m_run[i] = 0; m_wait[i] = 0; m_fin[i] = 0; m_pc[i] = 0; m_cyc[i] = 0;
      for (int k = 0; k < 16; k++) m_lut[i][k] = 0;
      return;
    end
    if (m_fin[i] != 0) begin
      if (!st) m_fin[i] = 0;
      return;
    end
    if (m_run[i] == 0) begin
      if (we) m_lut[i][waddr] = wdata;
      if (st) begin
        m_run[i] = 1; m_pc[i] = 0; m_cyc[i] = 0;
      end
      return;
    end
    if (m_cyc[i] < 65535) m_cyc[i]++;
    if (m_wait[i] > 0) begin
      m_wait[i]--;
      if (m_wait[i] == 0) m_pc[i] = (m_pc[i] + 1) % pcmod_of(i);
      return;
    end
    if (halt) begin
      m_run[i] = 0; m_fin[i] = 1;
      return;
    end
    if (mem && lat_of(i) > 0) begin
      m_wait[i] = lat_of(i);
      return;
    end
    if (jmp) m_pc[i] = m_lut[i][ptr];
    else     m_pc[i] = (m_pc[i] + 1) % pcmod_of(i);
  endtask

  task automatic cmp_all();
    check_eq("A.pc",     32'(a_pc),     m_pc[0]);
    check_eq("A.retire", 32'(a_retire), exp_retire(0, a_mem, a_halt));
    check_eq("A.stall",  32'(a_stall),  (m_wait[0] > 0) ? 1 : 0);
    check_eq("A.busy",   32'(a_busy),   m_run[0]);
    check_eq("A.done",   32'(a_done),   m_fin[0]);
    check_eq("A.cyc",    32'(a_cyc),    m_cyc[0]);
    check_eq("B.pc",     32'(b_pc),     m_pc[1]);
    check_eq("B.retire", 32'(b_retire), exp_retire(1, b_mem, b_halt));
    check_eq("B.stall",  32'(b_stall),  (m_wait[1] > 0) ? 1 : 0);
    check_eq("B.busy",   32'(b_busy),   m_run[1]);
    check_eq("B.done",   32'(b_done),   m_fin[1]);
    check_eq("B.cyc",    32'(b_cyc),    m_cyc[1]);
  endtask

  // Inputs are set at the falling edge; compare, then advance model on the rising edge.
  task automatic tick();
    #1;
    cmp_all();
    @(posedge clk);
    model_step(0, a_rst, a_start, a_jmp, a_ptr, a_mem, a_halt, a_we, a_waddr, int'(a_wdata));
    model_step(1, b_rst, b_start, b_jmp, b_ptr, b_mem, b_halt, b_we, b_waddr, int'(b_wdata));
    @(negedge clk);
  endtask

  task automatic clr_a();
    a_rst = 0; a_start = 0; a_jmp = 0; a_ptr = 0; a_mem = 0; a_halt = 0;
    a_we = 0; a_waddr = 0; a_wdata = 0;
  endtask

  task automatic clr_b();
    b_rst = 0; b_start = 0; b_jmp = 0; b_ptr = 0; b_mem = 0; b_halt = 0;
    b_we = 0; b_waddr = 0; b_wdata = 0;
  endtask

  int c0;

  initial begin
    clr_a();
    clr_b();
    a_rst = 1;
    b_rst = 1;
    model_step(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 0);
    model_step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    a_rst = 0;
    b_rst = 0;

    check_eq("rst.pc",   32'(a_pc),   0);
    check_eq("rst.done", 32'(a_done), 0);
    check_eq("rst.busy", 32'(a_busy), 0);
    check_eq("rst.cyc",  32'(a_cyc),  0);

    // Straight-line run of five instructions.
    a_start = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("seq.pc", 32'(a_pc), k);
      check_eq("seq.retire", 32'(a_retire), 1);
      tick();
    end
    check_eq("seq.cyc", 32'(a_cyc), 5);
    a_halt = 1; tick(); a_halt = 0;
    a_start = 0; tick();

    // Jump through LUT entry written in IDLE; write during RUN must be ignored.
    a_we = 1; a_waddr = 4'd3; a_wdata = 10'h120; a_start = 1;
    tick();
    a_we = 0;
    tick(); tick();
    check_eq("jmp.pc_before", 32'(a_pc), 2);
    a_jmp = 1; a_ptr = 4'd3;
    tick();
    a_jmp = 0;
    check_eq("jmp.target", 32'(a_pc), 32'h120);
    a_we = 1; a_waddr = 4'd3; a_wdata = 10'h055;
    tick();
    a_we = 0; a_jmp = 1; a_ptr = 4'd3;
    tick();
    a_jmp = 0;
    check_eq("jmp.lut_kept", 32'(a_pc), 32'h120);
    a_halt = 1; tick(); a_halt = 0;
    a_start = 0; tick();

    // Memory access at pc=5, then halt with competing inputs at pc=7.
    a_start = 1;
    tick();
    for (int k = 0; k < 5; k++) tick();
    c0 = int'(a_cyc);
    a_mem = 1;
    #1 check_eq("mem.retire_first", 32'(a_retire), 0);
    tick();
    a_mem = 0;
    #1;
    check_eq("mem.stall", 32'(a_stall), 1);
    check_eq("mem.retire_last", 32'(a_retire), 1);
    tick();
    check_eq("mem.pc_next", 32'(a_pc), 6);
    check_eq("mem.cyc_delta", 32'(a_cyc), c0 + 2);
    tick();
    a_halt = 1; a_jmp = 1; a_mem = 1; a_ptr = 4'd3;
    #1 check_eq("halt.retire", 32'(a_retire), 1);
    tick();
    a_halt = 0; a_jmp = 0; a_mem = 0;
    check_eq("halt.pc", 32'(a_pc), 7);
    check_eq("halt.done", 32'(a_done), 1);
    tick(); tick();
    check_eq("halt.done_held", 32'(a_done), 1);
    a_start = 0;
    tick();
    check_eq("halt.done_fall", 32'(a_done), 0);
    check_eq("halt.idle_busy", 32'(a_busy), 0);

    // Reset during STALL at pc=0x33 clears pc and the LUT.
    a_we = 1; a_waddr = 4'd1; a_wdata = 10'h033; a_start = 1;
    tick();
    a_we = 0; a_jmp = 1; a_ptr = 4'd1;
    tick();
    a_jmp = 0;
    check_eq("rstmid.pc", 32'(a_pc), 32'h33);
    a_mem = 1;
    tick();
    a_mem = 0;
    check_eq("rstmid.in_stall", 32'(a_stall), 1);
    a_rst = 1;
    tick();
    a_rst = 0;
    check_eq("rstmid.pc0", 32'(a_pc), 0);
    check_eq("rstmid.stall0", 32'(a_stall), 0);
    check_eq("rstmid.busy0", 32'(a_busy), 0);
    tick();
    a_jmp = 1; a_ptr = 4'd3;
    tick();
    a_jmp = 0;
    check_eq("rstmid.lut3", 32'(a_pc), 0);
    a_halt = 1; tick(); a_halt = 0;
    a_start = 0; tick();

    // Instance B: 3-cycle memory latency, 4-bit PC wrap and counter saturation.
    b_start = 1;
    tick();
    c0 = int'(b_cyc);
    b_mem = 1;
    tick();
    b_mem = 0;
    for (int k = 0; k < 3; k++) tick();
    check_eq("lat3.pc", 32'(b_pc), 1);
    check_eq("lat3.cyc", 32'(b_cyc), c0 + 4);
    for (int k = 0; k < 14; k++) tick();
    check_eq("wrap.pc15", 32'(b_pc), 15);
    tick();
    check_eq("wrap.pc0", 32'(b_pc), 0);
    for (int k = 0; k < 65540; k++) tick();
    check_eq("sat.cyc", 32'(b_cyc), 32'hFFFF);
    check_eq("sat.busy", 32'(b_busy), 1);
    b_halt = 1; tick(); b_halt = 0;
    b_start = 0; tick();

    // Randomized traffic on instance A.
    for (int k = 0; k < 3000; k++) begin
      a_rst   = ($urandom_range(0, 99) == 0);
      a_start = ($urandom_range(0, 9) < 8);
      a_jmp   = ($urandom_range(0, 3) == 0);
      a_ptr   = 4'($urandom_range(0, 15));
      a_mem   = ($urandom_range(0, 5) == 0);
      a_halt  = ($urandom_range(0, 24) == 0);
      a_we    = ($urandom_range(0, 2) == 0);
      a_waddr = 4'($urandom_range(0, 15));
      a_wdata = 10'($urandom_range(0, 1023));
      tick();
    end
    clr_a();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
